// File: rtl/otprom_prog_ctrl.sv
// otprom_prog_ctrl
// Sequencer and arbiter for the single read/program port of the OTP PROM cell
// array. It takes one host request at a time. A read is a single array read.
// A program first checks that the target value only sets bits (0->1). It then
// burns the missing bits with a timed pulse, and can optionally verify and retry.
//
// Optional feature macro: OTPROM_VERIFY_EN
//   defined     : after each pulse the word is read back and compared. Up to
//                 MAX_RETRY further pulses are issued if the compare fails.
//   not defined : the program pulse is trusted. The response reports err=0 and
//                 echoes the requested word.
//
// Every output comes straight from a flop. The async reset therefore drops
// m_ram_ren/m_ram_wen in the same instant that reset rises.
module otprom_prog_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PGM_CYCLES = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_retries,
    output logic [ADDR_W-1:0] m_ram_raddr,
    output logic              m_ram_ren,
    input  logic [DATA_W-1:0] m_ram_rdata,
    output logic [ADDR_W-1:0] m_ram_waddr,
    output logic [DATA_W-1:0] m_ram_wdata,
    output logic              m_ram_wen
);

    // Pulse counter holds PGM_CYCLES-1 down to 0
    localparam int CNT_W = (PGM_CYCLES > 1) ? $clog2(PGM_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(PGM_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Reject parameter values the sequencing cannot honour
    generate
        if ((PGM_CYCLES < 1) || (MAX_RETRY < 0) || (MAX_RETRY > 3)) begin : g_param_check
            $error("otprom_prog_ctrl: PGM_CYCLES must be >= 1 and MAX_RETRY within 0..3");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_CHK  = 3'd2,
        ST_PGM     = 3'd3,
`ifdef OTPROM_VERIFY_EN
        ST_VFY_RD  = 3'd4,
        ST_VFY_CHK = 3'd5,
`endif
        ST_RESP    = 3'd6
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                write_r, write_s;
    logic [DATA_W-1:0]   mask_r, mask_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [DATA_W-1:0]   resp_rdata_r, resp_rdata_s;
    logic                resp_err_r, resp_err_s;
    logic [1:0]          resp_retries_r, resp_retries_s;
    logic                req_ready_r, resp_valid_r, ren_r, wen_r;
`ifdef OTPROM_VERIFY_EN
    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
    logic [1:0]          retry_r, retry_s;
`endif

    // Next-state, request latching and response formation
    always_comb begin
        state_s        = state_r;
        addr_s         = addr_r;
        wdata_s        = wdata_r;
        write_s        = write_r;
        mask_s         = mask_r;
        cnt_s          = cnt_r;
        resp_rdata_s   = resp_rdata_r;
        resp_err_s     = resp_err_r;
        resp_retries_s = resp_retries_r;
`ifdef OTPROM_VERIFY_EN
        retry_s        = retry_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_s  = req_addr;
                    wdata_s = req_wdata;
                    write_s = req_write;
                    cnt_s   = CNT_ZERO;
`ifdef OTPROM_VERIFY_EN
                    retry_s = 2'd0;
`endif
                    state_s = ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_s = ST_RD_CHK;
            end
            ST_RD_CHK: begin
                if (!write_r) begin
                    resp_rdata_s   = m_ram_rdata;
                    resp_err_s     = 1'b0;
                    resp_retries_s = 2'd0;
                    state_s        = ST_RESP;
                end else if ((m_ram_rdata & ~wdata_r) != DATA_ZERO) begin
                    // would need a 1->0 transition: refuse without burning
                    resp_rdata_s   = m_ram_rdata;
                    resp_err_s     = 1'b1;
                    resp_retries_s = 2'd0;
                    state_s        = ST_RESP;
                end else if ((wdata_r & ~m_ram_rdata) == DATA_ZERO) begin
                    // word already holds the target value
                    resp_rdata_s   = m_ram_rdata;
                    resp_err_s     = 1'b0;
                    resp_retries_s = 2'd0;
                    state_s        = ST_RESP;
                end else begin
                    mask_s  = wdata_r & ~m_ram_rdata;
                    cnt_s   = CNT_LOAD;
                    state_s = ST_PGM;
                end
            end
            ST_PGM: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = ST_PGM;
                end else begin
`ifdef OTPROM_VERIFY_EN
                    state_s = ST_VFY_RD;
`else
                    resp_rdata_s   = wdata_r;
                    resp_err_s     = 1'b0;
                    resp_retries_s = 2'd0;
                    state_s        = ST_RESP;
`endif
                end
            end
`ifdef OTPROM_VERIFY_EN
            ST_VFY_RD: begin
                state_s = ST_VFY_CHK;
            end
            ST_VFY_CHK: begin
                if (m_ram_rdata == wdata_r) begin
                    resp_rdata_s   = m_ram_rdata;
                    resp_err_s     = 1'b0;
                    resp_retries_s = retry_r;
                    state_s        = ST_RESP;
                end else if (retry_r < RETRY_LIM) begin
                    retry_s = retry_r + 2'd1;
                    mask_s  = wdata_r & ~m_ram_rdata;
                    cnt_s   = CNT_LOAD;
                    state_s = ST_PGM;
                end else begin
                    resp_rdata_s   = m_ram_rdata;
                    resp_err_s     = 1'b1;
                    resp_retries_s = retry_r;
                    state_s        = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output flops; outputs are decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            addr_r         <= {ADDR_W{1'b0}};
            wdata_r        <= DATA_ZERO;
            write_r        <= 1'b0;
            mask_r         <= DATA_ZERO;
            cnt_r          <= CNT_ZERO;
            resp_rdata_r   <= DATA_ZERO;
            resp_err_r     <= 1'b0;
            resp_retries_r <= 2'd0;
            req_ready_r    <= 1'b1;
            resp_valid_r   <= 1'b0;
            ren_r          <= 1'b0;
            wen_r          <= 1'b0;
        end else begin
            state_r        <= state_s;
            addr_r         <= addr_s;
            wdata_r        <= wdata_s;
            write_r        <= write_s;
            mask_r         <= mask_s;
            cnt_r          <= cnt_s;
            resp_rdata_r   <= resp_rdata_s;
            resp_err_r     <= resp_err_s;
            resp_retries_r <= resp_retries_s;
            req_ready_r    <= (state_s == ST_IDLE);
            resp_valid_r   <= (state_s == ST_RESP);
`ifdef OTPROM_VERIFY_EN
            ren_r          <= (state_s == ST_RD) || (state_s == ST_VFY_RD);
`else
            ren_r          <= (state_s == ST_RD);
`endif
            wen_r          <= (state_s == ST_PGM);
        end
    end

`ifdef OTPROM_VERIFY_EN
    // Retry count of the current program request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_r <= 2'd0;
        end else begin
            retry_r <= retry_s;
        end
    end
`endif

    assign req_ready    = req_ready_r;
    assign resp_valid   = resp_valid_r;
    assign resp_rdata   = resp_rdata_r;
    assign resp_err     = resp_err_r;
    assign resp_retries = resp_retries_r;
    assign m_ram_raddr  = addr_r;
    assign m_ram_ren    = ren_r;
    assign m_ram_waddr  = addr_r;
    assign m_ram_wdata  = mask_r;
    assign m_ram_wen    = wen_r;

endmodule

// File: tb/tb_otprom_prog_ctrl.sv
// Directed bench for otprom_prog_ctrl with a small OTP array model.
// Cycle indices count falling edges after the accepting rising edge.
module tb_otprom_prog_ctrl;

    localparam int PC = 16;
`ifdef OTPROM_VERIFY_EN
    localparam int PGM_LAT  = 5 + PC;
    localparam int FAIL_LAT = 5 + PC + 3 * (PC + 2);
    localparam int FAIL_WEN = 4 * PC;
    localparam int PGM_REN  = 2;
`else
    localparam int PGM_LAT  = 3 + PC;
    localparam int FAIL_LAT = 3 + PC;
    localparam int FAIL_WEN = PC;
    localparam int PGM_REN  = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_retries;
    logic [31:0] m_ram_raddr;
    logic        m_ram_ren;
    logic [31:0] m_ram_rdata = 32'h0;
    logic [31:0] m_ram_waddr;
    logic [31:0] m_ram_wdata;
    logic        m_ram_wen;

    int checks = 0;
    int errors = 0;

    otprom_prog_ctrl #(
        .ADDR_W(32), .DATA_W(32), .PGM_CYCLES(PC), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_retries(resp_retries),
        .m_ram_raddr(m_ram_raddr), .m_ram_ren(m_ram_ren), .m_ram_rdata(m_ram_rdata),
        .m_ram_waddr(m_ram_waddr), .m_ram_wdata(m_ram_wdata), .m_ram_wen(m_ram_wen)
    );

    always #5 clk = ~clk;

    // OTP array model: program ORs bits in, read data returns the next cycle
    logic [31:0] mem [0:255];
    logic        ignore_wr = 1'b0;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_a = 8'h00;
    logic [31:0] pre_d = 32'h0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (m_ram_wen && !ignore_wr) mem[m_ram_waddr[7:0]] <= mem[m_ram_waddr[7:0]] | m_ram_wdata;
        if (m_ram_ren) m_ram_rdata <= mem[m_ram_raddr[7:0]];
    end

    // Per-transaction port monitor
    int rel = 0, acc_rel = 0, txn = 0, mon_txn = 0;
    int wen_cnt = 0, ren_cnt = 0, wen_first = 0, wen_last = 0, wd_bad = 0, both_cnt = 0;
    logic [31:0] wexp = 32'h0;
    always @(negedge clk) begin
        rel = rel + 1;
        if (mon_txn != txn) begin
            mon_txn = txn; wen_cnt = 0; ren_cnt = 0; wen_first = 0; wen_last = 0; wd_bad = 0;
        end
        if (m_ram_wen) begin
            if (wen_cnt == 0) wen_first = rel - acc_rel;
            wen_last = rel - acc_rel;
            wen_cnt = wen_cnt + 1;
            if (m_ram_wdata !== wexp) wd_bad = wd_bad + 1;
        end
        if (m_ram_ren) ren_cnt = ren_cnt + 1;
        if (m_ram_ren && m_ram_wen) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(posedge clk);
        acc_rel = rel;
        txn = txn + 1;
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 300);
    endtask

    int lat;
    int bad;
    logic [31:0] held;

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ren", {31'd0, m_ram_ren}, 32'd0);
        chk("rst_wen", {31'd0, m_ram_wen}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err_retries", {29'd0, resp_err, resp_retries}, 32'd0);
        chk("rst_raddr", m_ram_raddr, 32'd0);
        chk("rst_wdata", m_ram_wdata, 32'd0);
        preload(8'h05, 32'hA5A5_0000);
        preload(8'h10, 32'h0000_0000);
        preload(8'h20, 32'h0000_000F);
        preload(8'h30, 32'h0000_003C);
        preload(8'h40, 32'h0000_0000);
        preload(8'h50, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        // read, with the response held off for 10 cycles
        resp_ready = 1'b0;
        issue(1'b0, 32'h05, 32'h0);
        wait_resp(lat);
        chk("rd_latency", lat, 32'd3);
        chk("rd_rdata", resp_rdata, 32'hA5A5_0000);
        chk("rd_err", {31'd0, resp_err}, 32'd0);
        chk("rd_retries", {30'd0, resp_retries}, 32'd0);
        held = resp_rdata;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) bad++;
        end
        chk("rd_hold_stable", bad, 32'd0);
        chk("rd_ren_cycles", ren_cnt, 32'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rd_taken_valid", {31'd0, resp_valid}, 32'd0);
        chk("rd_taken_ready", {31'd0, req_ready}, 32'd1);

        // program 0x00 -> 0xFF
        wexp = 32'h0000_00FF;
        issue(1'b1, 32'h10, 32'h0000_00FF);
        wait_resp(lat);
        chk("pgm_latency", lat, PGM_LAT);
        chk("pgm_rdata", resp_rdata, 32'h0000_00FF);
        chk("pgm_err", {31'd0, resp_err}, 32'd0);
        chk("pgm_retries", {30'd0, resp_retries}, 32'd0);
        chk("pgm_wen_cycles", wen_cnt, PC);
        chk("pgm_wen_first", wen_first, 32'd3);
        chk("pgm_wen_last", wen_last, 2 + PC);
        chk("pgm_wdata_const", wd_bad, 32'd0);
        chk("pgm_ren_cycles", ren_cnt, PGM_REN);
        @(negedge clk);
        chk("pgm_resp_one_cycle", {31'd0, resp_valid}, 32'd0);

        // illegal program: would clear bit 0
        issue(1'b1, 32'h20, 32'h0000_000E);
        wait_resp(lat);
        chk("ill_latency", lat, 32'd3);
        chk("ill_err", {31'd0, resp_err}, 32'd1);
        chk("ill_rdata", resp_rdata, 32'h0000_000F);
        chk("ill_no_wen", wen_cnt, 32'd0);

        // no-op program
        issue(1'b1, 32'h30, 32'h0000_003C);
        wait_resp(lat);
        chk("nop_latency", lat, 32'd3);
        chk("nop_err", {31'd0, resp_err}, 32'd0);
        chk("nop_rdata", resp_rdata, 32'h0000_003C);
        chk("nop_no_wen", wen_cnt, 32'd0);

        // array ignores pulses: verify keeps failing
        ignore_wr = 1'b1;
        wexp = 32'h0000_00F0;
        issue(1'b1, 32'h40, 32'h0000_00F0);
        wait_resp(lat);
        chk("vf_latency", lat, FAIL_LAT);
        chk("vf_wen_cycles", wen_cnt, FAIL_WEN);
        chk("vf_wdata_const", wd_bad, 32'd0);
`ifdef OTPROM_VERIFY_EN
        chk("vf_err", {31'd0, resp_err}, 32'd1);
        chk("vf_retries", {30'd0, resp_retries}, 32'd3);
        chk("vf_rdata", resp_rdata, 32'h0000_0000);
`else
        chk("vf_err", {31'd0, resp_err}, 32'd0);
        chk("vf_retries", {30'd0, resp_retries}, 32'd0);
        chk("vf_rdata", resp_rdata, 32'h0000_00F0);
`endif
        @(negedge clk);
        ignore_wr = 1'b0;

        // reset during the fifth pulse cycle
        wexp = 32'h0000_0003;
        issue(1'b1, 32'h50, 32'h0000_0003);
        repeat (7) @(negedge clk);
        chk("rst_mid_wen_before", {31'd0, m_ram_wen}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_wen_drop", {31'd0, m_ram_wen}, 32'd0);
        chk("rst_mid_ren_drop", {31'd0, m_ram_ren}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || m_ram_wen !== 1'b0) bad++;
        end
        chk("rst_mid_quiet", bad, 32'd0);

        // read after reset, response taken immediately
        issue(1'b0, 32'h05, 32'h0);
        wait_resp(lat);
        chk("rd2_latency", lat, 32'd3);
        chk("rd2_rdata", resp_rdata, 32'hA5A5_0000);
        chk("rd2_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        chk("rd2_resp_one_cycle", {31'd0, resp_valid}, 32'd0);

        chk("ren_wen_exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
